// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder that sequences one fulladder cell LSB-first,
// with valid/ready handshakes on both the operand and result sides.
module fulladder (
    input  logic i0,
    input  logic i1,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = i0 ^ i1 ^ ci;
    assign co = (i0 & i1) | (ci & (i0 ^ i1));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
    logic [CW-1:0] cnt;
    logic carry, s, co, last;
    fulladder u_fa (.i0(a_sh[0]), .i1(b_sh[0]), .ci(carry), .s(s), .co(co));
    assign last = cnt == CW'(WIDTH - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx  = state;
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        busy      = state != IDLE;
        case (state)
            IDLE:    state_nx = in_valid ? RUN : IDLE;
            RUN:     state_nx = last ? DONE : RUN;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    // Operands only load on the IDLE handshake, so inputs are never sampled while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            sum_sh <= {s, sum_sh[WIDTH-1:1]};
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            carry  <= co;
            cnt    <= cnt + 1'b1;
            if (last) begin
                sum  <= {s, sum_sh[WIDTH-1:1]};
                cout <= co;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: drives WIDTH=8 and WIDTH=16 instances against a cycle-timed
// arithmetic scoreboard, plus directed literal checks on the 8-bit instance.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] iv = '0, ir, ci = '0, ov, ordy = '0, co, bz;
    logic [15:0] a[2], b[2];
    logic [7:0] s8;
    logic [15:0] s16;
    int n_chk = 0, n_fail = 0;
    int n = 0;
    bit m_busy[2] = '{0, 0};
    int m_done[2] = '{0, 0};
    int m_pend[2] = '{0, 0};
    int m_held[2] = '{0, 0};
    int m_cnt[2] = '{0, 0};
    logic [8:0] res0[$];

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a[0][7:0]), .b(b[0][7:0]), .cin(ci[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .sum(s8), .cout(co[0]), .busy(bz[0]));
    serial_adder #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a[1]), .b(b[1]), .cin(ci[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .sum(s16), .cout(co[1]), .busy(bz[1]));

    always #5 clk = ~clk;

    function automatic int wd(int i);
        return i == 0 ? 8 : 16;
    endfunction

    function automatic int opnd(int i, logic [15:0] v);
        return i == 0 ? int'(v[7:0]) : int'(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Timing model: a result is due WIDTH edges after its accepting edge and
    // stays presented until consumed; sum/cout hold the last completed result.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0;
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 0;
                m_held[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_busy[i]) begin
                    if (n >= m_done[i] && ordy[i]) begin
                        m_busy[i] = 0;
                        m_cnt[i]++;
                    end
                end else if (iv[i]) begin
                    m_busy[i] = 1;
                    m_done[i] = n + 1 + wd(i);
                    m_pend[i] = opnd(i, a[i]) + opnd(i, b[i]) + int'(ci[i]);
                end
            end
            n++;
            for (int i = 0; i < 2; i++)
                if (m_busy[i] && n == m_done[i]) m_held[i] = m_pend[i];
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk(i == 0 ? "w8_out_valid" : "w16_out_valid", 32'(ov[i]), 32'(m_busy[i] && n >= m_done[i]));
            chk(i == 0 ? "w8_in_ready" : "w16_in_ready", 32'(ir[i]), 32'(!m_busy[i]));
            chk(i == 0 ? "w8_busy" : "w16_busy", 32'(bz[i]), 32'(m_busy[i]));
            chk(i == 0 ? "w8_result" : "w16_result", i == 0 ? 32'({co[0], s8}) : 32'({co[1], s16}), m_held[i]);
        end
        if (ov[0] && ordy[0]) res0.push_back({co[0], s8});
    end

    task automatic send(input int i, input logic [15:0] x, input logic [15:0] y, input logic c);
        int g = 0;
        @(negedge clk);
        while (!ir[i] && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("send_ready", 32'(ir[i]), 32'd1);
        iv[i] = 1'b1;
        a[i] = x;
        b[i] = y;
        ci[i] = c;
        @(negedge clk);
        iv[i] = 1'b0;
    endtask

    task automatic await_out(input int i, output int lat);
        lat = 0;
        while (!ov[i] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("out_valid_wait", 32'(ov[i]), 32'd1);
    endtask

    task automatic consume(input int i);
        ordy[i] = 1'b1;
        @(negedge clk);
        ordy[i] = 1'b0;
    endtask

    task automatic op8(input string nm, input logic [7:0] x, input logic [7:0] y, input logic c, input logic [8:0] exp);
        int lat;
        send(0, 16'(x), 16'(y), c);
        await_out(0, lat);
        chk({nm, "_latency"}, 32'(lat), 32'd8);
        chk(nm, 32'({co[0], s8}), 32'(exp));
        consume(0);
    endtask

    task automatic rand_run(input int i, input int cnt);
        int g = 0;
        int target = m_cnt[i] + cnt;
        while (m_cnt[i] < target && g < 60000) begin
            @(negedge clk);
            g++;
            iv[i] = 1'($urandom_range(0, 1));
            a[i] = 16'($urandom);
            b[i] = 16'($urandom);
            ci[i] = 1'($urandom_range(0, 1));
            ordy[i] = $urandom_range(0, 3) != 0;
        end
        iv[i] = 1'b0;
        ordy[i] = 1'b1;
        chk(i == 0 ? "w8_rand_count" : "w16_rand_count", 32'(m_cnt[i] >= target), 32'd1);
    endtask

    initial begin
        int hs[3];
        int lat;
        a[0] = '0; b[0] = '0; a[1] = '0; b[1] = '0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 32'(ir[0]), 32'd1);
        chk("reset_out_valid", 32'(ov[0]), 32'd0);
        chk("reset_sum", 32'({co[0], s8}), 32'd0);
        rst_n = 1'b1;

        op8("basic", 8'h5A, 8'h3C, 1'b0, 9'h096);
        op8("ripple", 8'hFF, 8'h01, 1'b0, 9'h100);
        op8("all_ones", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
        op8("cin_only", 8'h00, 8'h00, 1'b1, 9'h001);

        send(0, 16'h12, 16'h34, 1'b0);
        await_out(0, lat);
        for (int k = 0; k < 5; k++) begin
            iv[0] = ~iv[0];
            a[0] = 16'($urandom);
            b[0] = 16'($urandom);
            @(negedge clk);
            chk("bp_valid", 32'(ov[0]), 32'd1);
            chk("bp_in_ready", 32'(ir[0]), 32'd0);
            chk("bp_sum", 32'({co[0], s8}), 32'h046);
        end
        iv[0] = 1'b0;
        consume(0);
        chk("bp_release_ready", 32'(ir[0]), 32'd1);
        chk("bp_release_valid", 32'(ov[0]), 32'd0);

        send(0, 16'hAA, 16'h55, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(ov[0]), 32'd0);
        chk("midrst_in_ready", 32'(ir[0]), 32'd1);
        chk("midrst_busy", 32'(bz[0]), 32'd0);
        chk("midrst_sum", 32'({co[0], s8}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op8("after_rst", 8'h10, 8'h20, 1'b0, 9'h030);

        res0.delete();
        iv[0] = 1'b1;
        ordy[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int g = 0;
            a[0] = k == 0 ? 16'h01 : k == 1 ? 16'h80 : 16'h7F;
            b[0] = k == 0 ? 16'h01 : k == 1 ? 16'h80 : 16'h01;
            ci[0] = 1'b0;
            while (!ir[0] && g < 50) begin
                @(negedge clk);
                g++;
            end
            hs[k] = n + 1;
            @(negedge clk);
        end
        iv[0] = 1'b0;
        repeat (12) @(negedge clk);
        ordy[0] = 1'b0;
        chk("b2b_gap1", 32'(hs[1] - hs[0]), 32'd10);
        chk("b2b_gap2", 32'(hs[2] - hs[1]), 32'd10);
        chk("b2b_count", 32'(res0.size()), 32'd3);
        if (res0.size() == 3) begin
            chk("b2b_res0", 32'(res0[0]), 32'h002);
            chk("b2b_res1", 32'(res0[1]), 32'h100);
            chk("b2b_res2", 32'(res0[2]), 32'h080);
        end

        fork
            rand_run(0, 500);
            rand_run(1, 500);
        join
        repeat (40) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder controller wrapped around a single `fulladder` cell instance.
- Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Each cycle, it feeds one bit pair LSB-first into the full adder, captures `s`/`co` into a sum shift register and a carry flop, and returns the WIDTH-bit sum plus carry-out on an output valid/ready handshake.
- Serves as the sequential datapath stage that drives and consumes the gate-level full adder in area-constrained arithmetic.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
clk  input  1  single clock, all flops rising-edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands a, b, cin valid.
in_ready  output  1  block can accept operands (high only in IDLE).
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in.
out_valid  output  1  sum/cout valid (high only in DONE).
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  registered sum.
cout  output  1  registered carry-out.
busy  output  1  high in RUN or DONE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is `clk`, reset port is `rst_n`.
- Reset (asynchronous on `rst_n` low):
  - state=IDLE.
  - Operand shift registers, sum register, carry flop, bit counter: all 0.
  - sum=0, cout=0, out_valid=0, busy=0, in_ready=1.
  - Reset asserted mid-RUN or mid-DONE abandons the operation; no partial result is ever presented.
- States: IDLE, RUN, DONE. Encoding is free; outputs are decoded from state.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0; go to RUN.
  - Operands are sampled only on this handshake edge.
- RUN (exactly WIDTH cycles):
  - fulladder inputs: i0=a_sh[0], i1=b_sh[0], ci=carry.
  - Each edge:
    - sum_sh <= {s, sum_sh[WIDTH-1:1]}.
    - a_sh, b_sh shift right by 1 (zero fill).
    - carry <= co.
    - cnt <= cnt+1.
  - When cnt==WIDTH-1, the same edge also transfers the final value into sum/cout and goes to DONE.
  - in_ready=0; in_valid and operand changes are ignored.
- DONE:
  - out_valid=1; sum and cout held stable.
  - On out_ready=1: go to IDLE, out_valid falls next cycle.
  - sum/cout retain their last value after leaving DONE until the next result overwrites them.
- Latency and throughput:
  - Input handshake at edge E → out_valid high after edge E+WIDTH.
  - With out_ready held high, the next input is accepted no earlier than edge E+WIDTH+2.
  - Throughput is one result per WIDTH+2 cycles.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); exact, no saturation.
- Counter: width clog2(WIDTH); it never wraps within an operation.
- Simultaneous events:
  - in_valid in DONE: ignored until IDLE is re-entered.
  - out_ready outside DONE: ignored.
  - X on a/b while in_ready=0: must not propagate.
- Purely synchronous datapath apart from reset. No combinational path from in_valid to out_valid or from out_ready to in_ready.

Test Plan:
- Basic add: WIDTH=8, a=0x5A, b=0x3C, cin=0, in_valid for 1 cycle → out_valid rises exactly 8 cycles after the handshake; sum=0x96, cout=0.
- Carry ripple and boundaries:
  - a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1.
  - a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
  - a=0x00, b=0x00, cin=1 → sum=0x01, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid with new operands → sum/cout/out_valid stable, in_ready=0, no new operand captured. Release out_ready → IDLE next cycle.
- Reset mid-operation: deassert rst_n at the 3rd RUN cycle of a=0xAA+b=0x55 → out_valid=0, in_ready=1, busy=0, sum=0 immediately. Next op 0x10+0x20 → sum=0x30, cout=0.
- Back-to-back stream: in_valid and out_ready held high, three operand pairs (0x01+0x01, 0x80+0x80, 0x7F+0x01) → results 0x02/0, 0x00/1, 0x80/0, with handshakes spaced exactly 10 cycles apart.
- Randomized check, WIDTH=8 and WIDTH=16: 1000 random operands with random out_ready stalls → every result matches a+b+cin against the scoreboard.
